// File: rtl/imem_pkg.sv
// Shared constants and encodings for the instruction memory port arbiter.
package imem_pkg;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 10;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    typedef enum logic {
        GNT_FETCH  = 1'b0,
        GNT_LOADER = 1'b1
    } gnt_e;

endpackage

// File: rtl/imem_port_arbiter_rr.sv
// Two-input round-robin arbiter (fetch vs loader) with last-grant memory.
module rr_arbiter2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_f_i,
    input  logic req_l_i,
    output logic gnt_f_o,
    output logic gnt_l_o
);

    gnt_e last_q, last_d;

    always_comb begin
        gnt_f_o = 1'b0;
        gnt_l_o = 1'b0;
        if (en_i) begin
            if (req_f_i && req_l_i) begin
                gnt_f_o = (last_q == GNT_LOADER);
                gnt_l_o = (last_q == GNT_FETCH);
            end else begin
                gnt_f_o = req_f_i;
                gnt_l_o = req_l_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_f_o) begin
            last_d = GNT_FETCH;
        end else if (gnt_l_o) begin
            last_d = GNT_LOADER;
        end
    end

    // Loader counts as last winner out of reset so fetch wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_LOADER;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one sync-read imem between the fetch stage and the loader port.
module imem_port_arbiter
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req_valid,
    input  logic [31:0]           f_req_addr,
    output logic                  f_req_ready,
    input  logic                  f_flush,
    output logic                  f_rsp_valid,
    output logic [DATA_W-1:0]     f_rsp_data,
    input  logic                  l_req_valid,
    input  logic                  l_req_we,
    input  logic [31:0]           l_req_addr,
    input  logic [DATA_W-1:0]     l_req_wdata,
    output logic                  l_req_ready,
    input  logic                  l_lock,
    output logic                  l_rsp_valid,
    output logic [DATA_W-1:0]     l_rsp_data,
    output logic                  l_rsp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e state_q, state_d;
    logic   fetch_en;
    logic   gnt_f, gnt_l;
    logic   l_mis, l_mem;

    logic              f_pend_q, f_pend_d;
    logic              l_pend_q, l_pend_d;
    logic              l_zero_q, l_zero_d;
    logic              l_err_q,  l_err_d;
    logic [DATA_W-1:0] f_hold_q, f_hold_d;
    logic [DATA_W-1:0] l_hold_q, l_hold_d;
    logic [DATA_W-1:0] l_data_now;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_req_addr[31:DEPTH_LOG2+2],
                                f_req_addr[1:0],
                                l_req_addr[31:DEPTH_LOG2+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARB:  if (l_lock)  state_d = ST_LOCK;
            ST_LOCK: if (!l_lock) state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == ST_ARB);
    end

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (!rst),
        .req_f_i (f_req_valid && fetch_en),
        .req_l_i (l_req_valid),
        .gnt_f_o (gnt_f),
        .gnt_l_o (gnt_l)
    );

    assign f_req_ready = gnt_f;
    assign l_req_ready = gnt_l;

    // Misaligned loader requests are accepted but never reach the array.
    assign l_mis = |l_req_addr[1:0];
    assign l_mem = gnt_l && !l_mis;

    always_comb begin
        mem_en    = gnt_f || l_mem;
        mem_we    = l_mem && l_req_we;
        mem_wdata = l_req_wdata;
        mem_addr  = gnt_f ? f_req_addr[DEPTH_LOG2+1:2]
                          : l_req_addr[DEPTH_LOG2+1:2];
    end

    always_comb begin
        f_pend_d = gnt_f;
        l_pend_d = gnt_l;
        l_zero_d = gnt_l && (l_mis || l_req_we);
        l_err_d  = gnt_l && l_mis;
    end

    assign f_rsp_valid = f_pend_q && !f_flush && !rst;
    assign f_rsp_data  = f_rsp_valid ? mem_rdata : f_hold_q;
    assign f_hold_d    = f_rsp_data;

    assign l_data_now  = l_zero_q ? '0 : mem_rdata;
    assign l_rsp_valid = l_pend_q && !rst;
    assign l_rsp_data  = l_rsp_valid ? l_data_now : l_hold_q;
    assign l_rsp_err   = l_rsp_valid && l_err_q;
    assign l_hold_d    = l_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pend_q <= 1'b0;
            l_pend_q <= 1'b0;
            l_zero_q <= 1'b0;
            l_err_q  <= 1'b0;
            f_hold_q <= '0;
            l_hold_q <= '0;
        end else begin
            f_pend_q <= f_pend_d;
            l_pend_q <= l_pend_d;
            l_zero_q <= l_zero_d;
            l_err_q  <= l_err_d;
            f_hold_q <= f_hold_d;
            l_hold_q <= l_hold_d;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a behavioural sync-read imem.
module tb_imem_port_arbiter;
    import imem_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  f_req_valid;
    logic [31:0]           f_req_addr;
    logic                  f_req_ready;
    logic                  f_flush;
    logic                  f_rsp_valid;
    logic [DATA_W-1:0]     f_rsp_data;
    logic                  l_req_valid;
    logic                  l_req_we;
    logic [31:0]           l_req_addr;
    logic [DATA_W-1:0]     l_req_wdata;
    logic                  l_req_ready;
    logic                  l_lock;
    logic                  l_rsp_valid;
    logic [DATA_W-1:0]     l_rsp_data;
    logic                  l_rsp_err;
    logic                  mem_en;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    int errors = 0;
    int checks = 0;

    logic [31:0] fq [$];
    logic [32:0] lq [$];

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_flush     (f_flush),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .l_req_valid (l_req_valid),
        .l_req_we    (l_req_we),
        .l_req_addr  (l_req_addr),
        .l_req_wdata (l_req_wdata),
        .l_req_ready (l_req_ready),
        .l_lock      (l_lock),
        .l_rsp_valid (l_rsp_valid),
        .l_rsp_data  (l_rsp_data),
        .l_rsp_err   (l_rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Word i initially holds 0xA500_0000 + i.
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
            mem[i] = 32'hA500_0000 + i;
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [32:0] act,
                       input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (f_rsp_valid === 1'b1) begin
            if (fq.size() == 0) chk("f_rsp_unexpected", {32'd0, f_rsp_valid}, 33'd0);
            else chk("f_rsp_data", {1'b0, f_rsp_data}, {1'b0, fq.pop_front()});
        end
        if (l_rsp_valid === 1'b1) begin
            if (lq.size() == 0) chk("l_rsp_unexpected", {32'd0, l_rsp_valid}, 33'd0);
            else chk("l_rsp_err_data", {l_rsp_err, l_rsp_data}, lq.pop_front());
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req_valid = 1'b0;
        l_req_valid = 1'b0;
        l_req_we    = 1'b0;
        f_flush     = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        f_req_valid = 1'b1;
        f_req_addr  = a;
    endtask

    task automatic lreq(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        l_req_valid = 1'b1;
        l_req_we    = we;
        l_req_addr  = a;
        l_req_wdata = d;
    endtask

    initial begin
        rst = 1'b1; l_lock = 1'b0;
        f_req_addr = '0; l_req_addr = '0; l_req_wdata = '0;
        idle();
        repeat (3) go();
        fetch(32'h0);
        lreq(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("rst_f_ready", {32'd0, f_req_ready}, 33'd0);
        chk("rst_l_ready", {32'd0, l_req_ready}, 33'd0);
        chk("rst_mem_en", {32'd0, mem_en}, 33'd0);
        chk("rst_rsp_valids", {31'd0, f_rsp_valid, l_rsp_valid}, 33'd0);
        chk("rst_f_data", {1'b0, f_rsp_data}, 33'd0);
        chk("rst_l_data", {l_rsp_err, l_rsp_data}, 33'd0);

        // Fetch only, back to back.
        go(); rst = 1'b0; idle();
        for (int i = 0; i < 3; i++) begin
            go();
            fetch(i * 4);
            @(negedge clk);
            chk("t1_f_ready", {32'd0, f_req_ready}, 33'd1);
            chk("t1_mem", {mem_en, mem_we, 21'd0, mem_addr}, {2'b10, 21'd0, 10'(i)});
            fq.push_back(32'hA500_0000 + i);
        end
        go(); idle();

        // Contention straight out of reset: F,L,F,L.
        go(); rst = 1'b1;
        go(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            go();
            fetch(32'h0C);
            lreq(1'b0, 32'h10, 32'h0);
            @(negedge clk);
            chk("t2_grants", {31'd0, f_req_ready, l_req_ready},
                (i % 2 == 0) ? 33'b10 : 33'b01);
            if (i % 2 == 0) fq.push_back(32'hA500_0003);
            else lq.push_back({1'b0, 32'hA500_0004});
        end
        go(); idle();

        // Lock rises while a fetch is accepted; that fetch still returns.
        go(); l_lock = 1'b1; fetch(32'h20);
        @(negedge clk);
        chk("t3_last_arb_f_ready", {32'd0, f_req_ready}, 33'd1);
        fq.push_back(32'hA500_0008);
        go(); fetch(32'h0); lreq(1'b1, 32'h0, 32'h00a00093);
        @(negedge clk);
        chk("t3_lock_grants", {31'd0, f_req_ready, l_req_ready}, 33'b01);
        chk("t3_mem_wr", {mem_en, mem_we, 21'd0, mem_addr}, {2'b11, 31'd0});
        chk("t3_mem_wdata", {1'b0, mem_wdata}, {1'b0, 32'h00a00093});
        lq.push_back(33'd0);
        go(); lreq(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t3_lock_rd_grants", {31'd0, f_req_ready, l_req_ready}, 33'b01);
        lq.push_back({1'b0, 32'h00a00093});
        go(); l_lock = 1'b0; l_req_valid = 1'b0;
        @(negedge clk);
        chk("t3_release_delay", {32'd0, f_req_ready}, 33'd0);
        go();
        @(negedge clk);
        chk("t3_after_release", {32'd0, f_req_ready}, 33'd1);
        fq.push_back(32'h00a00093);
        go(); idle();

        // Misaligned write: no access, error response, still counts as loader grant.
        go(); lreq(1'b1, 32'h06, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t4_mis_ready_en", {31'd0, l_req_ready, mem_en}, 33'b10);
        lq.push_back({1'b1, 32'h0});
        go(); fetch(32'h30); lreq(1'b0, 32'h04, 32'h0);
        @(negedge clk);
        chk("t4_last_is_loader", {31'd0, f_req_ready, l_req_ready}, 33'b10);
        fq.push_back(32'hA500_000C);
        go(); f_req_valid = 1'b0;
        @(negedge clk);
        chk("t4_rd_ready", {32'd0, l_req_ready}, 33'd1);
        lq.push_back({1'b0, 32'hA500_0001});
        go(); idle();

        // Flush drops 0x84's response; a fetch issued alongside proceeds.
        go(); fetch(32'h84);
        @(negedge clk);
        chk("t5_f_ready", {32'd0, f_req_ready}, 33'd1);
        go(); f_flush = 1'b1; fetch(32'h8C);
        @(negedge clk);
        chk("t5_flush_ready", {32'd0, f_req_ready}, 33'd1);
        chk("t5_flushed_valid", {32'd0, f_rsp_valid}, 33'd0);
        fq.push_back(32'hA500_0023);
        go(); idle();

        // Reset while a loader read is in flight.
        go(); lreq(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t6_l_ready", {32'd0, l_req_ready}, 33'd1);
        go(); rst = 1'b1; l_req_valid = 1'b0; fetch(32'h0C);
        @(negedge clk);
        chk("t6_rst_l_valid", {32'd0, l_rsp_valid}, 33'd0);
        chk("t6_rst_f_ready", {32'd0, f_req_ready}, 33'd0);
        go(); rst = 1'b0; f_req_valid = 1'b0;
        @(negedge clk);
        chk("t6_post_l_valid", {32'd0, l_rsp_valid}, 33'd0);
        go(); fetch(32'h0C); lreq(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t6_first_contention", {31'd0, f_req_ready, l_req_ready}, 33'b10);
        fq.push_back(32'hA500_0003);
        go(); idle();

        repeat (3) go();
        chk("fq_drained", 33'(fq.size()), 33'd0);
        chk("lq_drained", 33'(lq.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares one single-port, word-addressed instruction memory between two requesters. The CPU fetch stage issues reads only. The program loader/debug port issues reads and writes. The block sits between the fetch stage, the loader and the imem array. The array has a synchronous read and replaces the asynchronous ROM once programs are downloaded at run time.

Parameters:
DATA_W, 32, instruction/data word width
DEPTH_LOG2, 10, log2 of memory depth in words (1024 words)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
f_req_valid  input  1  fetch read request
f_req_addr  input  32  fetch byte address
f_req_ready  output  1  fetch request accepted this cycle
f_flush  input  1  discard the fetch response due next cycle (branch redirect)
f_rsp_valid  output  1  fetch read data valid
f_rsp_data  output  DATA_W  fetch read data
l_req_valid  input  1  loader request
l_req_we  input  1  1 = write, 0 = read
l_req_addr  input  32  loader byte address
l_req_wdata  input  DATA_W  loader write data
l_req_ready  output  1  loader request accepted this cycle
l_lock  input  1  loader exclusive mode (fetch blocked)
l_rsp_valid  output  1  loader response valid (read data or write ack)
l_rsp_data  output  DATA_W  loader read data (0 for writes)
l_rsp_err  output  1  loader request rejected (misaligned)
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  DEPTH_LOG2  word address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Word address = byte address [DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Acceptance: a request is accepted when valid and ready are both high in the same cycle. At most one request is accepted per cycle. Ready is a combinational grant.
- Memory drive: on the acceptance cycle, mem_en=1 and mem_addr/mem_we/mem_wdata are driven combinationally. With no grant, mem_en=0 and mem_we=0.
- Response timing: exactly one cycle after acceptance. Responses have no backpressure. Fetch data = mem_rdata. Loader read data = mem_rdata; writes return l_rsp_data=0.
- Latency: 1 cycle. Full throughput of one access per cycle, back to back.
- FSM states:
  - ARB: round-robin between fetch and loader. last_grant register; if both are valid, grant the one not granted last; otherwise grant the sole requester.
  - LOCK: only the loader is served; f_req_ready=0.
- FSM transitions: ARB->LOCK when l_lock=1. LOCK->ARB when l_lock=0. The transition takes effect the cycle after l_lock changes; the arbitration in the cycle l_lock rises still follows ARB rules.
- In-flight responses: a fetch accepted in the last ARB cycle still returns its response during LOCK.
- Misalignment: a loader request with addr[1:0]!=0 is accepted (ready as normal) but produces no memory access (mem_en=0). The next cycle gives l_rsp_valid=1, l_rsp_err=1, l_rsp_data=0. last_grant still updates to loader. Fetch addr[1:0] is ignored.
- Flush: f_flush=1 in the cycle a fetch response is due forces f_rsp_valid=0. f_flush does not block a new fetch request in the same cycle; that new request's response follows normally.
- Output registers: f_rsp_data and l_rsp_data hold their last values when the corresponding valid is low.
- Reset values: last_grant=loader (fetch wins the first contention); state=ARB; f_rsp_valid=0, l_rsp_valid=0, l_rsp_err=0, f_rsp_data=0, l_rsp_data=0.
- Reset mid-operation: any in-flight response is dropped, so no valid appears in the cycle after rst. Combinational readies are 0 while rst=1.

Decomposition:
- Shared package imem_pkg: DATA_W, DEPTH_LOG2, state encoding (ST_ARB, ST_LOCK), grant encoding (GNT_FETCH, GNT_LOADER).
- One natural sub-module: rr_arbiter2 (2-input round-robin with last-grant register and enable input). The FSM, response pipeline and misalign check remain in the top module.

Test Plan:
- Fetch only: f_req_valid=1 at addresses 0x00, 0x04, 0x08 on consecutive cycles -> f_req_ready=1 each cycle, mem_addr=0,1,2, and f_rsp_data equals mem words 0,1,2 one cycle later.
- Contention: both requesters valid for 4 cycles after reset -> grants alternate F,L,F,L; loader reads of 0x10 return word 4.
- Lock download: l_lock=1, loader writes 0x00a00093 to 0x00 while fetch is valid -> f_req_ready=0 throughout; a loader read-back returns 0x00a00093; after release, fetch of 0x00 returns 0x00a00093.
- Misaligned write: loader write to 0x06 -> mem_en=0; next cycle l_rsp_valid=1, l_rsp_err=1; a read of 0x04 is unchanged.
- Flush: fetch of 0x84 accepted, f_flush=1 next cycle alongside a new fetch of 0x8c -> no response for 0x84; word 0x23 (0x8c) is returned the cycle after.
- Reset mid-op: assert rst in the cycle after a loader read is accepted -> l_rsp_valid=0 then and after; the first contention after reset is granted to fetch.
